// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// register-index sizing.
package alu_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_LAND = 4'd9;
  localparam logic [3:0] OP_LOR  = 4'd10;
  localparam logic [3:0] OP_LXOR = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Eight-entry register file: two asynchronous read ports, host write port
// with an ALU writeback override that wins on an address collision; r0 is zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]     wb_data
);

  logic [WIDTH-1:0] regs_r [NUM_REGS];

  assign rd_data_a = regs_r[rd_addr_a];
  assign rd_data_b = regs_r[rd_addr_b];

  // Register storage; writeback takes precedence over a host write to the same entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      regs_r[0] <= {WIDTH{1'b0}};
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_en && (wb_addr == REG_IDX_W'(i))) begin
          regs_r[i] <= wb_data;
        end else if (wr_en && (wr_addr == REG_IDX_W'(i))) begin
          regs_r[i] <= wr_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts register-indexed ALU commands, drives an external combinational ALU
// for one cycle, writes back the result and holds a response until taken.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [REG_IDX_W-1:0] cmd_dst,
  input  logic [REG_IDX_W-1:0] cmd_srca,
  input  logic [REG_IDX_W-1:0] cmd_srcb,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_op,
  output logic                 alu_enable,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_overflow,
  input  logic                 alu_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_error,
  output logic [7:0]           err_count
);

  state_t                 state_r, state_s;
  logic [3:0]             op_r;
  logic [REG_IDX_W-1:0]   dst_r, srca_r, srcb_r;
  logic [WIDTH-1:0]       rd_a_s, rd_b_s;
  logic                   wb_en_s;
  logic                   rsp_valid_r, rsp_overflow_r, rsp_error_r;
  logic [WIDTH-1:0]       rsp_result_r;
  logic [7:0]             err_count_r;

  // A faulting ALU operation never updates the destination
  assign wb_en_s = (state_r == ST_ISSUE) && !alu_error;

  alu_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (srca_r),
    .rd_data_a (rd_a_s),
    .rd_addr_b (srcb_r),
    .rd_data_b (rd_b_s),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wb_en     (wb_en_s),
    .wb_addr   (dst_r),
    .wb_data   (alu_result)
  );

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (cmd_valid) state_s = ST_ISSUE; else state_s = ST_IDLE;
      ST_ISSUE:   state_s = ST_RESPOND;
      ST_RESPOND: if (rsp_ready) state_s = ST_IDLE; else state_s = ST_RESPOND;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Handshake and ALU drive, decoded from the current state
  always_comb begin
    cmd_ready  = 1'b0;
    alu_enable = 1'b0;
    alu_a      = {WIDTH{1'b0}};
    alu_b      = {WIDTH{1'b0}};
    alu_op     = 4'd0;
    case (state_r)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_ISSUE: begin
        alu_enable = 1'b1;
        alu_a      = rd_a_s;
        alu_b      = rd_b_s;
        alu_op     = op_r;
      end
      ST_RESPOND: cmd_ready = 1'b0;
      default:    cmd_ready = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Command latch, response capture and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r           <= 4'd0;
      dst_r          <= {REG_IDX_W{1'b0}};
      srca_r         <= {REG_IDX_W{1'b0}};
      srcb_r         <= {REG_IDX_W{1'b0}};
      rsp_valid_r    <= 1'b0;
      rsp_result_r   <= {WIDTH{1'b0}};
      rsp_overflow_r <= 1'b0;
      rsp_error_r    <= 1'b0;
      err_count_r    <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r   <= cmd_op;
            dst_r  <= cmd_dst;
            srca_r <= cmd_srca;
            srcb_r <= cmd_srcb;
          end
        end
        ST_ISSUE: begin
          rsp_valid_r    <= 1'b1;
          rsp_result_r   <= alu_result;
          rsp_overflow_r <= alu_overflow;
          rsp_error_r    <= alu_error;
          if (alu_error && (err_count_r != 8'd255)) err_count_r <= err_count_r + 8'd1;
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_r    <= 1'b0;
            rsp_result_r   <= {WIDTH{1'b0}};
            rsp_overflow_r <= 1'b0;
            rsp_error_r    <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_overflow = rsp_overflow_r;
  assign rsp_error    = rsp_error_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: external ALU model, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_srca, cmd_srcb;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_enable, alu_overflow, alu_error;
  logic        rsp_valid, rsp_ready, rsp_overflow, rsp_error;
  logic [31:0] rsp_result;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .err_count(err_count)
  );

  // Reference ALU: returns {error, overflow, result}
  function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        o, e;
    logic [63:0] p;
    r = 32'd0; o = 1'b0; e = 1'b0;
    p = 64'(a) * 64'(b);
    case (op)
      OP_ADD:  begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB:  begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_MUL:  begin r = p[31:0]; o = (p[63:32] != 32'd0); end
      OP_DIV:  if (b == 32'd0) e = 1'b1; else r = a / b;
      OP_MOD:  if (b == 32'd0) e = 1'b1; else r = a % b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_LAND: r = {31'd0, (a != 32'd0) && (b != 32'd0)};
      OP_LOR:  r = {31'd0, (a != 32'd0) || (b != 32'd0)};
      OP_LXOR: r = {31'd0, (a != 32'd0) ^ (b != 32'd0)};
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: e = 1'b1;
    endcase
    return {e, o, r};
  endfunction

  always_comb {alu_error, alu_overflow, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  // Transaction-level model: phase 0 waiting, 1 operating, 2 response held
  logic [31:0] m_regs [8];
  int          m_phase;
  logic [3:0]  m_op;
  logic [2:0]  m_dst, m_srca, m_srcb;
  logic [31:0] m_res;
  logic        m_ovf, m_err;
  int          m_errcnt;
  logic [33:0] m_alu;

  always_comb m_alu = alu_fn(m_op, m_regs[m_srca], m_regs[m_srcb]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 32'd0;
      m_phase <= 0; m_op <= 4'd0; m_dst <= 3'd0; m_srca <= 3'd0; m_srcb <= 3'd0;
      m_res <= 32'd0; m_ovf <= 1'b0; m_err <= 1'b0; m_errcnt <= 0;
    end else begin
      if (wr_en && wr_addr != 3'd0) m_regs[wr_addr] <= wr_data;
      case (m_phase)
        0: if (cmd_valid) begin
          m_op <= cmd_op; m_dst <= cmd_dst; m_srca <= cmd_srca; m_srcb <= cmd_srcb;
          m_phase <= 1;
        end
        1: begin
          m_res <= m_alu[31:0]; m_ovf <= m_alu[32]; m_err <= m_alu[33];
          if (!m_alu[33] && m_dst != 3'd0) m_regs[m_dst] <= m_alu[31:0];
          if (m_alu[33] && m_errcnt < 255) m_errcnt <= m_errcnt + 1;
          m_phase <= 2;
        end
        2: if (rsp_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("cmd_ready",    {31'd0, cmd_ready},    {31'd0, m_phase == 0});
    chk("alu_enable",   {31'd0, alu_enable},   {31'd0, m_phase == 1});
    chk("alu_a",        alu_a,  (m_phase == 1) ? m_regs[m_srca] : 32'd0);
    chk("alu_b",        alu_b,  (m_phase == 1) ? m_regs[m_srcb] : 32'd0);
    chk("alu_op",       {28'd0, alu_op}, (m_phase == 1) ? {28'd0, m_op} : 32'd0);
    chk("rsp_valid",    {31'd0, rsp_valid},    {31'd0, m_phase == 2});
    chk("rsp_result",   rsp_result, (m_phase == 2) ? m_res : 32'd0);
    chk("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, (m_phase == 2) && m_ovf});
    chk("rsp_error",    {31'd0, rsp_error},    {31'd0, (m_phase == 2) && m_err});
    chk("err_count",    {24'd0, err_count},    32'(m_errcnt));
  end

  logic [31:0] cap_a, cap_b, cap_res;
  logic        cap_ovf, cap_err;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issues a command, optionally with a host write during the operate cycle;
  // returns in the first response cycle with results captured.
  task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sb, input logic do_wr, input logic [2:0] wa,
                       input logic [31:0] wd);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
    tick();
    cmd_valid = 1'b0;
    chk("lat_issue", {31'd0, alu_enable}, 32'd1);
    cap_a = alu_a; cap_b = alu_b;
    wr_en = do_wr; wr_addr = wa; wr_data = wd;
    tick();
    wr_en = 1'b0;
    chk("lat_rsp", {31'd0, rsp_valid}, 32'd1);
    cap_res = rsp_result; cap_ovf = rsp_overflow; cap_err = rsp_error;
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sa, input logic [2:0] sb);
    issue(op, dst, sa, sb, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_dst = 3'd0; cmd_srca = 3'd0; cmd_srcb = 3'd0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'd0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_err_count", {24'd0, err_count}, 32'd0);

    // Basic add and register readback
    load(3'd1, 32'd5); load(3'd2, 32'd7);
    send(OP_ADD, 3'd3, 3'd1, 3'd2);
    chk("add_a", cap_a, 32'd5); chk("add_b", cap_b, 32'd7);
    chk("add_res", cap_res, 32'd12); chk("add_flags", {30'd0, cap_ovf, cap_err}, 32'd0);
    tick();
    send(OP_OR, 3'd0, 3'd3, 3'd0); chk("r3_after_add", cap_a, 32'd12); tick();

    // Overlapping source and destination
    send(OP_ADD, 3'd3, 3'd3, 3'd3); chk("overlap_res", cap_res, 32'd24); tick();
    send(OP_OR, 3'd0, 3'd3, 3'd0); chk("overlap_r3", cap_a, 32'd24); tick();

    // Signed overflow
    load(3'd1, 32'h7FFF_FFFF); load(3'd2, 32'd1);
    send(OP_ADD, 3'd4, 3'd1, 3'd2);
    chk("ovf_res", cap_res, 32'h8000_0000); chk("ovf_flag", {31'd0, cap_ovf}, 32'd1);
    tick();
    send(OP_OR, 3'd0, 3'd4, 3'd0); chk("r4_written", cap_a, 32'h8000_0000); tick();

    // Divide by zero: error, no writeback
    load(3'd1, 32'd9); load(3'd5, 32'h55);
    send(OP_DIV, 3'd5, 3'd1, 3'd0);
    chk("div0_err", {31'd0, cap_err}, 32'd1);
    tick();
    chk("div0_err_count", {24'd0, err_count}, 32'd1);
    send(OP_OR, 3'd0, 3'd5, 3'd0); chk("r5_unchanged", cap_a, 32'h55); tick();
    send(OP_SUB, 3'd6, 3'd1, 3'd5); chk("sub_res", cap_res, 32'hFFFF_FFB4); tick();
    send(OP_MUL, 3'd7, 3'd1, 3'd5); chk("mul_res", cap_res, 32'h2FD); tick();

    // Response back-pressure
    rsp_ready = 1'b0;
    send(OP_XOR, 3'd6, 3'd1, 3'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_result", rsp_result, 32'h5C);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Host write colliding with writeback: ALU wins
    load(3'd1, 32'd5); load(3'd2, 32'd7);
    issue(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b1, 3'd6, 32'hAAAA);
    chk("collide_res", cap_res, 32'd12); tick();
    send(OP_OR, 3'd0, 3'd6, 3'd0); chk("collide_r6", cap_a, 32'd12); tick();

    // Host write to a source during the operate cycle: old operand used, write kept
    issue(OP_ADD, 3'd7, 3'd1, 3'd2, 1'b1, 3'd1, 32'd100);
    chk("issue_old_a", cap_a, 32'd5); chk("issue_old_res", cap_res, 32'd12); tick();
    send(OP_OR, 3'd0, 3'd1, 3'd7);
    chk("host_wr_kept", cap_a, 32'd100); chk("r7_written", cap_b, 32'd12); tick();

    // r0 stays zero
    load(3'd0, 32'h1234);
    send(OP_OR, 3'd0, 3'd0, 3'd0); chk("r0_zero", cap_a, 32'd0); tick();

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin send(OP_DIV, 3'd0, 3'd1, 3'd0); tick(); end
    chk("err_saturate", {24'd0, err_count}, 32'd255);

    // Reset during a held response
    rsp_ready = 1'b0;
    send(OP_ADD, 3'd3, 3'd1, 3'd2);
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b1;
    send(OP_ADD, 3'd0, 3'd1, 3'd3);
    chk("post_rst_r1", cap_a, 32'd0); chk("post_rst_r3", cap_b, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
